// File: rtl/xgsoc_pkg.sv
// Shared constants, decode enum and state type for the xgsoc peripheral core.
package xgsoc_pkg;

    localparam logic [31:0] IO_BASE = 32'h2000_0000;

    localparam logic [7:0] OFF_DISPLAY     = 8'h00;
    localparam logic [7:0] OFF_UART_DATA   = 8'h04;
    localparam logic [7:0] OFF_UART_STATUS = 8'h08;
    localparam logic [7:0] OFF_KBD_DATA    = 8'h0C;
    localparam logic [7:0] OFF_KBD_STATUS  = 8'h10;

    localparam int US_TX_BUSY    = 0;
    localparam int US_RX_VALID   = 1;
    localparam int US_RX_OVERRUN = 2;

    localparam int KS_NOT_EMPTY = 0;
    localparam int KS_FULL      = 1;
    localparam int KS_OVERFLOW  = 2;
    localparam int KS_ERR       = 3;

    typedef enum logic [1:0] {RAM, IO, UNMAPPED} access_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // RAM window wins over the I/O page should the two ever overlap.
    function automatic access_t decode_access(input logic [31:0] addr, input logic [32:0] ram_size);
        if ({1'b0, addr} < ram_size) return RAM;
        if (addr[31:8] == IO_BASE[31:8]) return IO;
        return UNMAPPED;
    endfunction

endpackage

// File: rtl/xgsoc_uart.sv
// 8N1 UART: transmitter and receiver, each bit lasting DIV clock cycles.
module xgsoc_uart
    import xgsoc_pkg::*;
#(
    parameter int DIV = 17
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_o,
    input  logic       rx_i,
    output logic       rx_done,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    uart_state_t   tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    tx_shift_reg;
    logic          tx_line, tx_o_reg, tx_tick;

    assign tx_tick = (tx_cnt_reg == BIT_END);
    assign tx_o    = tx_o_reg;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) tx_state_reg <= IDLE;
        else          tx_state_reg <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            IDLE:  if (tx_start) tx_state_next = START;
            START: if (tx_tick) tx_state_next = DATA;
            DATA:  if (tx_tick && tx_bit_reg == 3'd7) tx_state_next = STOP;
            STOP:  if (tx_tick) tx_state_next = IDLE;
            default: tx_state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        tx_busy = (tx_state_reg != IDLE);
        case (tx_state_reg)
            START:   tx_line = 1'b0;
            DATA:    tx_line = tx_shift_reg[0];
            default: tx_line = 1'b1;
        endcase
    end

    // The line is re-registered so the start bit appears the cycle after the state leaves IDLE.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_o_reg     <= 1'b1;
        end else begin
            tx_o_reg <= tx_line;
            if (tx_state_reg == IDLE) begin
                tx_cnt_reg <= '0;
                tx_bit_reg <= '0;
                if (tx_start) tx_shift_reg <= tx_data;
            end else begin
                tx_cnt_reg <= tx_tick ? '0 : tx_cnt_reg + 1'b1;
                if (tx_state_reg == DATA && tx_tick) begin
                    tx_bit_reg   <= tx_bit_reg + 1'b1;
                    tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                end
            end
        end
    end

    uart_state_t   rx_state_reg, rx_state_next;
    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg, rx_byte_reg;
    logic          rx_tick, rx_half;

    assign rx_tick = (rx_cnt_reg == BIT_END);
    assign rx_half = (rx_cnt_reg == HALF_END);
    assign rx_byte = rx_byte_reg;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) rx_state_reg <= IDLE;
        else          rx_state_reg <= rx_state_next;
    end

    // A start bit that is high again at mid-bit is treated as a glitch.
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = START;
            START: if (rx_half) rx_state_next = rx_sync_reg ? IDLE : DATA;
            DATA:  if (rx_tick && rx_bit_reg == 3'd7) rx_state_next = STOP;
            STOP:  if (rx_tick) rx_state_next = IDLE;
            default: rx_state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_done = (rx_state_reg == STOP) && rx_tick && rx_sync_reg;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte_reg  <= '0;
        end else begin
            rx_meta_reg <= rx_i;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            case (rx_state_reg)
                IDLE: begin
                    rx_cnt_reg <= '0;
                    rx_bit_reg <= '0;
                end
                START:   rx_cnt_reg <= rx_half ? '0 : rx_cnt_reg + 1'b1;
                default: rx_cnt_reg <= rx_tick ? '0 : rx_cnt_reg + 1'b1;
            endcase
            if (rx_state_reg == DATA && rx_tick) begin
                rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                rx_bit_reg   <= rx_bit_reg + 1'b1;
            end
            if (rx_done) rx_byte_reg <= rx_shift_reg;
        end
    end

endmodule

// File: rtl/xgsoc_core.sv
// Bus decode for the xgsoc CPU: RAM pass-through plus an I/O page with display, UART and keyboard FIFO.
module xgsoc_core
    import xgsoc_pkg::*;
#(
    parameter int     FREQ_HZ  = 2_000_000,
    parameter int     BAUDS    = 115200,
    parameter longint RAM_SIZE = 16 * 1024 * 1024
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic [3:0]  bus_wstrb_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [7:0]  display_o,
    input  logic        rx_i,
    output logic        tx_o,
    input  logic [7:0]  ps2_kbd_code_i,
    input  logic        ps2_kbd_strobe_i,
    input  logic        ps2_kbd_err_i
);
    localparam int DIV = FREQ_HZ / BAUDS;

    access_t     acc;
    logic        ram_sel, ram_active, io_fire, io_wr, io_rd;
    logic [7:0]  off;
    logic        ack_reg;
    logic [31:0] rdata_reg, rdata_next;
    logic [7:0]  display_reg;
    logic        tx_start, tx_busy, rx_done;
    logic [7:0]  rx_byte;
    logic        rx_valid_reg, rx_overrun_reg, kbd_ovf_reg, kbd_err_reg;
    logic        rd_uart_data, rd_uart_status, rd_kbd_data, rd_kbd_status;

    logic [7:0]  fifo_mem [16];
    logic [3:0]  wr_ptr_reg, rd_ptr_reg;
    logic [4:0]  count_reg;
    logic        kbd_full, kbd_not_empty, push, pop;

    assign acc        = decode_access(bus_addr_i, 33'(RAM_SIZE));
    assign ram_sel    = (acc == RAM);
    assign ram_active = bus_req_i & ram_sel;
    assign off        = bus_addr_i[7:0];

    assign mem_req_o   = ram_active;
    assign mem_we_o    = bus_we_i;
    assign mem_addr_o  = bus_addr_i;
    assign mem_wdata_o = bus_wdata_i;
    assign mem_wstrb_o = bus_wstrb_i;

    // ack_reg doubles as the blocker: a request still high during its ack cycle cannot fire again.
    assign io_fire = bus_req_i & ~ram_sel & ~ack_reg;
    assign io_wr   = io_fire & (acc == IO) & bus_we_i;
    assign io_rd   = io_fire & (acc == IO) & ~bus_we_i;

    assign bus_ack_o   = ram_active ? mem_ack_i   : ack_reg;
    assign bus_rdata_o = ram_active ? mem_rdata_i : rdata_reg;
    assign display_o   = display_reg;

    assign tx_start       = io_wr & (off == OFF_UART_DATA) & ~tx_busy;
    assign rd_uart_data   = io_rd & (off == OFF_UART_DATA);
    assign rd_uart_status = io_rd & (off == OFF_UART_STATUS);
    assign rd_kbd_data    = io_rd & (off == OFF_KBD_DATA);
    assign rd_kbd_status  = io_rd & (off == OFF_KBD_STATUS);

    assign kbd_full      = (count_reg == 5'd16);
    assign kbd_not_empty = (count_reg != 5'd0);
    assign push          = ps2_kbd_strobe_i & ~kbd_full;
    assign pop           = rd_kbd_data & kbd_not_empty;

    xgsoc_uart #(.DIV(DIV)) u_uart (
        .clk      (clk),
        .reset_i  (reset_i),
        .tx_start (tx_start),
        .tx_data  (bus_wdata_i[7:0]),
        .tx_busy  (tx_busy),
        .tx_o     (tx_o),
        .rx_i     (rx_i),
        .rx_done  (rx_done),
        .rx_byte  (rx_byte)
    );

    always_comb begin
        rdata_next = '0;
        if (io_rd) begin
            case (off)
                OFF_DISPLAY:   rdata_next[7:0] = display_reg;
                OFF_UART_DATA: rdata_next[7:0] = rx_byte;
                OFF_UART_STATUS: begin
                    rdata_next[US_TX_BUSY]    = tx_busy;
                    rdata_next[US_RX_VALID]   = rx_valid_reg;
                    rdata_next[US_RX_OVERRUN] = rx_overrun_reg;
                end
                OFF_KBD_DATA: if (kbd_not_empty) rdata_next[7:0] = fifo_mem[rd_ptr_reg];
                OFF_KBD_STATUS: begin
                    rdata_next[KS_NOT_EMPTY] = kbd_not_empty;
                    rdata_next[KS_FULL]      = kbd_full;
                    rdata_next[KS_OVERFLOW]  = kbd_ovf_reg;
                    rdata_next[KS_ERR]       = kbd_err_reg;
                end
                default: rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= ps2_kbd_code_i;
    end

    // New events take priority over a clear-on-read landing on the same edge.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            ack_reg        <= 1'b0;
            rdata_reg      <= '0;
            display_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
            kbd_ovf_reg    <= 1'b0;
            kbd_err_reg    <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            ack_reg   <= io_fire;
            rdata_reg <= rdata_next;
            if (io_wr && off == OFF_DISPLAY) display_reg <= bus_wdata_i[7:0];

            if (rx_done)           rx_valid_reg <= 1'b1;
            else if (rd_uart_data) rx_valid_reg <= 1'b0;
            if (rx_done && rx_valid_reg && !rd_uart_data) rx_overrun_reg <= 1'b1;
            else if (rd_uart_status)                       rx_overrun_reg <= 1'b0;

            if (ps2_kbd_strobe_i && kbd_full) kbd_ovf_reg <= 1'b1;
            else if (rd_kbd_status)           kbd_ovf_reg <= 1'b0;
            if (ps2_kbd_err_i)                kbd_err_reg <= 1'b1;
            else if (rd_kbd_status)           kbd_err_reg <= 1'b0;

            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {4'b0, push} - {4'b0, pop};
        end
    end

endmodule

// File: tb/tb_xgsoc_core.sv
// Randomized directed bench for xgsoc_core against a queue/arithmetic reference model.
module tb_xgsoc_core;
    localparam int DIV = 17;
    localparam logic [31:0] IOB = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        bus_req_i = 1'b0, bus_we_i = 1'b0;
    logic [31:0] bus_addr_i = '0, bus_wdata_i = '0;
    logic [3:0]  bus_wstrb_i = '0;
    logic [31:0] bus_rdata_o;
    logic        bus_ack_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  display_o;
    logic        rx_i = 1'b1;
    logic        tx_o;
    logic [7:0]  ps2_kbd_code_i = '0;
    logic        ps2_kbd_strobe_i = 1'b0, ps2_kbd_err_i = 1'b0;

    xgsoc_core #(.FREQ_HZ(2_000_000), .BAUDS(115200), .RAM_SIZE(16 * 1024 * 1024)) dut (
        .clk(clk), .reset_i(reset_i),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
        .bus_wdata_i(bus_wdata_i), .bus_wstrb_i(bus_wstrb_i),
        .bus_rdata_o(bus_rdata_o), .bus_ack_o(bus_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .display_o(display_o), .rx_i(rx_i), .tx_o(tx_o),
        .ps2_kbd_code_i(ps2_kbd_code_i), .ps2_kbd_strobe_i(ps2_kbd_strobe_i),
        .ps2_kbd_err_i(ps2_kbd_err_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    int         last_ack_cyc;
    logic [7:0] last_disp_req, last_disp_ack;
    logic       last_tx_ack, last_tx_next;

    logic [7:0] model_display = '0;
    logic [7:0] kq[$];
    logic       model_ovf = 1'b0, model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [7:0] t;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        t = b >> (k - 1);
        return t[0];
    endfunction

    function automatic logic [31:0] kbd_status_model();
        return {28'd0, model_err, model_ovf, kq.size() == 16, kq.size() != 0};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge; ends #1 after the idle edge that follows the dropped request.
    task automatic io_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic strobe_en, input logic [7:0] code, output logic [31:0] rdata);
        bus_req_i = 1'b1; bus_we_i = we; bus_addr_i = addr; bus_wdata_i = wdata;
        bus_wstrb_i = 4'($urandom);
        if (strobe_en) begin
            ps2_kbd_strobe_i = 1'b1;
            ps2_kbd_code_i = code;
        end
        last_disp_req = display_o;
        check("ack_before_edge", bus_ack_o, 1'b0);
        check("mem_req_on_io", mem_req_o, 1'b0);
        @(posedge clk); #1;
        ps2_kbd_strobe_i = 1'b0;
        check("ack_pulse", bus_ack_o, 1'b1);
        rdata = bus_rdata_o;
        last_ack_cyc = cyc;
        last_disp_ack = display_o;
        last_tx_ack = tx_o;
        @(posedge clk); #1;
        check("ack_single", bus_ack_o, 1'b0);
        last_tx_next = tx_o;
        bus_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ram_access(input logic we, input logic [31:0] addr);
        logic [31:0] wd, rd;
        logic [3:0]  ws;
        int          lat;
        wd = $urandom; rd = $urandom; ws = 4'($urandom); lat = $urandom_range(1, 4);
        bus_req_i = 1'b1; bus_we_i = we; bus_addr_i = addr; bus_wdata_i = wd; bus_wstrb_i = ws;
        #1;
        check("mem_req", mem_req_o, 1'b1);
        check("mem_addr", mem_addr_o, addr);
        check("mem_fields", {mem_we_o, mem_wstrb_o, mem_wdata_o}, {we, ws, wd});
        check("ram_ack_wait", bus_ack_o, 1'b0);
        repeat (lat) @(posedge clk);
        #1;
        mem_ack_i = 1'b1; mem_rdata_i = rd;
        #1;
        check("ram_ack", bus_ack_o, 1'b1);
        check("ram_rdata", bus_rdata_o, rd);
        @(posedge clk); #1;
        mem_ack_i = 1'b0; mem_rdata_i = '0; bus_req_i = 1'b0;
        #1;
        check("mem_req_drop", mem_req_o, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_i = (k == 9) ? stop : frame_bit(b, k);
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx_i = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask

    task automatic kbd_push(input logic [7:0] code);
        ps2_kbd_strobe_i = 1'b1; ps2_kbd_code_i = code;
        if (kq.size() < 16) kq.push_back(code);
        else model_ovf = 1'b1;
        @(posedge clk); #1;
        ps2_kbd_strobe_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, v;
        logic [7:0]  b, b2, code;
        int          c0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_display", display_o, 8'h00);
        check("rst_tx", tx_o, 1'b1);
        check("rst_ack", bus_ack_o, 1'b0);
        check("rst_rdata", bus_rdata_o, 32'h0);
        reset_i = 1'b1;
        @(posedge clk); #1;
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rst_uart_status", rd, 32'h0);
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("rst_kbd_status", rd, 32'h0);

        // Display register
        io_access(1, IOB, {24'($urandom), 8'hA5}, 0, 0, rd);
        check("disp_before_ack", last_disp_req, model_display);
        model_display = 8'hA5;
        check("disp_at_ack", last_disp_ack, model_display);
        io_access(0, IOB, 0, 0, 0, rd); check("disp_readback", rd, 32'h0000_00A5);
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            io_access(1, IOB, v, 0, 0, rd);
            model_display = v[7:0];
            check("disp_rand_ack", last_disp_ack, model_display);
            io_access(0, IOB, 0, 0, 0, rd); check("disp_rand_read", rd, {24'd0, model_display});
        end

        // UART transmit: frame shape, dropped write while busy, busy duration
        b = 8'($urandom);
        io_access(1, IOB + 32'h04, {24'($urandom), b}, 0, 0, rd);
        c0 = last_ack_cyc;
        check("tx_idle_in_ack", last_tx_ack, 1'b1);
        check("tx_start_after_ack", last_tx_next, 1'b0);
        for (int k = 0; k < 10; k++) begin
            wait_cyc(c0 + 1 + DIV * k + DIV / 2);
            check($sformatf("tx_bit%0d", k), tx_o, frame_bit(b, k));
            if (k == 2) io_access(1, IOB + 32'h04, {24'd0, ~b}, 0, 0, rd);
        end
        wait_cyc(c0 + 10 * DIV - 1);
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("tx_busy_last", rd, 32'h1);
        b2 = 8'($urandom);
        io_access(1, IOB + 32'h04, {24'd0, b2}, 0, 0, rd);
        c0 = last_ack_cyc;
        wait_cyc(c0 + 1 + DIV / 2);
        check("tx2_start", tx_o, 1'b0);
        wait_cyc(c0 + 10 * DIV);
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("tx_busy_end", rd, 32'h0);
        check("tx_idle_line", tx_o, 1'b1);

        // UART receive
        b = 8'($urandom);
        uart_send(b, 1'b1);
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rx_valid", rd, 32'h2);
        io_access(0, IOB + 32'h04, 0, 0, 0, rd); check("rx_data", rd, {24'd0, b});
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rx_valid_clr", rd, 32'h0);
        uart_send(8'($urandom), 1'b0);
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rx_bad_stop", rd, 32'h0);
        b = 8'($urandom); b2 = 8'($urandom);
        uart_send(b, 1'b1);
        uart_send(b2, 1'b1);
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rx_overrun", rd, 32'h6);
        io_access(0, IOB + 32'h04, 0, 0, 0, rd); check("rx_overrun_data", rd, {24'd0, b2});
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rx_overrun_clr", rd, 32'h0);

        // Keyboard FIFO fill, overflow, drain
        for (int i = 0; i < 17; i++) begin
            kbd_push(8'($urandom_range(1, 255)));
            if (i == 0 || i == 15 || i == 16) begin
                io_access(0, IOB + 32'h10, 0, 0, 0, rd);
                check($sformatf("kbd_status_after_%0d", i + 1), rd, kbd_status_model());
                model_ovf = 1'b0; model_err = 1'b0;
            end
        end
        for (int i = 0; i < 17; i++) begin
            v = (kq.size() != 0) ? {24'd0, kq.pop_front()} : 32'h0;
            io_access(0, IOB + 32'h0C, 0, 0, 0, rd);
            check($sformatf("kbd_pop%0d", i), rd, v);
        end
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("kbd_empty", rd, kbd_status_model());
        ps2_kbd_err_i = 1'b1; @(posedge clk); #1; ps2_kbd_err_i = 1'b0; model_err = 1'b1;
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("kbd_err", rd, kbd_status_model());
        model_err = 1'b0;
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("kbd_err_clr", rd, kbd_status_model());

        // Simultaneous push and pop with three entries queued
        for (int i = 0; i < 3; i++) kbd_push(8'($urandom));
        code = 8'($urandom);
        v = {24'd0, kq.pop_front()};
        kq.push_back(code);
        io_access(0, IOB + 32'h0C, 0, 1'b1, code, rd); check("kbd_pushpop_data", rd, v);
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("kbd_pushpop_status", rd, kbd_status_model());
        for (int i = 0; i < 4; i++) begin
            v = (kq.size() != 0) ? {24'd0, kq.pop_front()} : 32'h0;
            io_access(0, IOB + 32'h0C, 0, 0, 0, rd);
            check($sformatf("kbd_order%0d", i), rd, v);
        end

        // RAM window, boundaries, unmapped and unused I/O offsets
        ram_access(1'b1, 32'h0000_1000);
        ram_access(1'b0, 32'h0000_1000);
        ram_access(1'b0, 32'h00FF_FFFC);
        for (int i = 0; i < 3; i++) ram_access(1'($urandom), $urandom_range(0, 32'h00FF_FFFF) & 32'hFFFF_FFFC);
        io_access(0, 32'h4000_0000, 0, 0, 0, rd); check("unmapped_read", rd, 32'h0);
        io_access(0, 32'h0100_0000, 0, 0, 0, rd); check("ram_end_unmapped", rd, 32'h0);
        io_access(1, 32'h4000_0000, $urandom, 0, 0, rd);
        check("unmapped_write_ignored", display_o, model_display);
        io_access(0, IOB + 32'h14, 0, 0, 0, rd); check("io_unused_read", rd, 32'h0);

        // Asynchronous reset in the middle of a transmit frame
        kbd_push(8'h5A);
        io_access(1, IOB + 32'h04, 32'h0, 0, 0, rd);
        repeat (40) @(posedge clk);
        #1;
        check("tx_mid_frame_low", tx_o, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        check("rst_async_tx", tx_o, 1'b1);
        check("rst_async_display", display_o, 8'h00);
        model_display = '0; kq.delete(); model_ovf = 1'b0; model_err = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        io_access(0, IOB + 32'h08, 0, 0, 0, rd); check("rst_mid_uart", rd, 32'h0);
        io_access(0, IOB + 32'h10, 0, 0, 0, rd); check("rst_mid_kbd", rd, kbd_status_model());
        check("rst_mid_tx_line", tx_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
